// File: rtl/lsu_mc.sv
// Multicycle load/store unit driving the dm_8k data-memory port.
// One command at a time: IDLE -> ADDR -> ACCESS -> DONE, errored commands skip ACCESS.
module lsu_mc #(
    parameter int unsigned DM_AW       = 11,
    parameter bit          CHECK_RANGE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [31:0]      addr_in,
    input  logic [31:0]      wdata_in,
    input  logic [31:0]      dm_dout,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      rdata_out,
    output logic [DM_AW-1:0] dm_addr,
    output logic [3:0]       dm_be,
    output logic [31:0]      dm_din,
    output logic             dm_we
);

    localparam int unsigned RANGE_SHIFT = DM_AW + 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADDR   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q;
    logic [31:0] addr_q;

    logic        op_legal;
    logic        misaligned;
    logic        out_of_range;
    logic        cmd_err;
    logic        is_store;
    logic        accept;
    logic [3:0]  be_c;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Byte enables derived from the incoming command so they are valid throughout ADDR
    always_comb begin
        be_c = 4'b0000;
        case (op[1:0])
            2'b00:   be_c = 4'b0001 << addr_in[1:0];
            2'b01:   be_c = addr_in[1] ? 4'b1100 : 4'b0011;
            2'b10:   be_c = 4'b1111;
            default: be_c = 4'b0000;
        endcase
    end

    // Command checks on the latched command
    always_comb begin
        op_legal = 1'b0;
        case (op_q)
            4'b0000, 4'b0001, 4'b0010,
            4'b0100, 4'b0101,
            4'b1000, 4'b1001, 4'b1010: op_legal = 1'b1;
            default:                   op_legal = 1'b0;
        endcase
        misaligned   = ((op_q[1:0] == 2'b01) && addr_q[0])
                    || ((op_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        out_of_range = CHECK_RANGE && ((addr_q >> RANGE_SHIFT) != 32'd0);
        cmd_err      = !op_legal || misaligned || out_of_range;
        is_store     = op_q[3];
    end

    // Lane extraction and sign/zero extension of the memory word
    always_comb begin
        ld_byte = dm_dout[7:0];
        case (addr_q[1:0])
            2'b00:   ld_byte = dm_dout[7:0];
            2'b01:   ld_byte = dm_dout[15:8];
            2'b10:   ld_byte = dm_dout[23:16];
            default: ld_byte = dm_dout[31:24];
        endcase
        ld_half = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];
        ld_ext  = dm_dout;
        case (op_q[2:0])
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = dm_dout;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_ADDR:   state_d = cmd_err ? S_DONE : S_ACCESS;
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; dm_we is high exactly while in ACCESS for a store
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= 4'd0;
            addr_q    <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            dm_we     <= 1'b0;
            rdata_out <= 32'd0;
            dm_addr   <= '0;
            dm_be     <= 4'd0;
            dm_din    <= 32'd0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != S_IDLE);
            done    <= (state_d == S_DONE);
            err     <= (state_q == S_ADDR) && cmd_err;
            dm_we   <= (state_q == S_ADDR) && !cmd_err && is_store;
            if (accept) begin
                op_q    <= op;
                addr_q  <= addr_in;
                dm_addr <= addr_in[DM_AW+1:2];
                dm_be   <= be_c;
                dm_din  <= wdata_in;
            end
            if ((state_q == S_ACCESS) && !is_store) begin
                rdata_out <= ld_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mc.sv
// Self-checking bench for lsu_mc with a behavioural dm_8k model (falling-edge write, lane steering).
module tb_lsu_mc;

    localparam int unsigned DM_AW = 11;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       op;
    logic [31:0]      addr_in;
    logic [31:0]      wdata_in;
    logic [31:0]      dm_dout;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      rdata_out;
    logic [DM_AW-1:0] dm_addr;
    logic [3:0]       dm_be;
    logic [31:0]      dm_din;
    logic             dm_we;

    lsu_mc #(.DM_AW(DM_AW), .CHECK_RANGE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .addr_in(addr_in),
        .wdata_in(wdata_in), .dm_dout(dm_dout), .busy(busy), .done(done), .err(err),
        .rdata_out(rdata_out), .dm_addr(dm_addr), .dm_be(dm_be), .dm_din(dm_din),
        .dm_we(dm_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dm_8k model: writes on the falling edge, din[7:0]/din[15:0] steered to the enabled lane
    logic [31:0] mem [0:(1<<DM_AW)-1];
    logic        preload;
    int          we_cnt;
    initial we_cnt = 0;
    assign dm_dout = mem[dm_addr];

    always @(negedge clk) begin
        if (preload) begin
            mem[4] = 32'h8899AABB;
        end else if (dm_we === 1'b1) begin
            we_cnt = we_cnt + 1;
            case (dm_be)
                4'b0001: mem[dm_addr][7:0]   = dm_din[7:0];
                4'b0010: mem[dm_addr][15:8]  = dm_din[7:0];
                4'b0100: mem[dm_addr][23:16] = dm_din[7:0];
                4'b1000: mem[dm_addr][31:24] = dm_din[7:0];
                4'b0011: mem[dm_addr][15:0]  = dm_din[15:0];
                4'b1100: mem[dm_addr][31:16] = dm_din[15:0];
                4'b1111: mem[dm_addr]        = dm_din;
                default: ;
            endcase
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  be;
        logic        chk_be;
        int          lat;
        int          we;
    } vec_t;

    vec_t tbl [20];
    vec_t exp_q [$];
    int   n_cmp;
    int   n_bad;

    function automatic vec_t mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w,
                                input logic [31:0] rd, input logic e, input logic [3:0] be,
                                input logic cb, input int we);
        vec_t v;
        v.op = o; v.addr = a; v.wdata = w; v.rdata = rd; v.err = e;
        v.be = be; v.chk_be = cb; v.lat = e ? 2 : 3; v.we = we;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input int idx);
        vec_t v;
        vec_t e;
        int   cyc;
        int   we0;
        v = tbl[idx];
        @(negedge clk);
        start = 1'b1; op = v.op; addr_in = v.addr; wdata_in = v.wdata;
        exp_q.push_back(v);
        we0 = we_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check($sformatf("v%0d_addr", idx), 32'(dm_addr), 32'(v.addr[DM_AW+1:2]));
        check($sformatf("v%0d_din", idx), dm_din, v.wdata);
        if (v.chk_be) check($sformatf("v%0d_be", idx), 32'(dm_be), 32'(v.be));
        while (done !== 1'b1 && cyc < 8) begin
            @(posedge clk); #1;
            cyc = cyc + 1;
        end
        e = exp_q.pop_front();
        if (done !== 1'b1) begin
            check($sformatf("v%0d_timeout", idx), 32'(done), 32'd1);
        end else begin
            check($sformatf("v%0d_lat", idx), 32'(cyc), 32'(e.lat));
            check($sformatf("v%0d_err", idx), 32'(err), 32'(e.err));
            check($sformatf("v%0d_rdata", idx), rdata_out, e.rdata);
        end
        @(posedge clk); #1;
        check($sformatf("v%0d_idle", idx), {29'd0, busy, done, err}, 32'd0);
        check($sformatf("v%0d_we", idx), 32'(we_cnt - we0), 32'(e.we));
    endtask

    initial begin
        int dn;
        int we0;
        int pos [$];
        n_cmp = 0; n_bad = 0;
        start = 1'b0; op = 4'd0; addr_in = 32'd0; wdata_in = 32'd0;
        rst_n = 1'b0; preload = 1'b1;

        tbl[0]  = mk(4'b0000, 32'h13, 32'hDEAD0000, 32'hFFFFFF88, 1'b0, 4'b1000, 1'b1, 0);
        tbl[1]  = mk(4'b0100, 32'h13, 32'hDEAD0001, 32'h00000088, 1'b0, 4'b1000, 1'b1, 0);
        tbl[2]  = mk(4'b0001, 32'h12, 32'hDEAD0002, 32'hFFFF8899, 1'b0, 4'b1100, 1'b1, 0);
        tbl[3]  = mk(4'b0101, 32'h10, 32'hDEAD0003, 32'h0000AABB, 1'b0, 4'b0011, 1'b1, 0);
        tbl[4]  = mk(4'b0010, 32'h10, 32'hDEAD0004, 32'h8899AABB, 1'b0, 4'b1111, 1'b1, 0);
        tbl[5]  = mk(4'b1001, 32'h12, 32'h00001234, 32'h8899AABB, 1'b0, 4'b1100, 1'b1, 1);
        tbl[6]  = mk(4'b0010, 32'h10, 32'hDEAD0006, 32'h1234AABB, 1'b0, 4'b1111, 1'b1, 0);
        tbl[7]  = mk(4'b1010, 32'h11, 32'h55555555, 32'h1234AABB, 1'b1, 4'b1111, 1'b1, 0);
        tbl[8]  = mk(4'b0001, 32'h11, 32'hDEAD0008, 32'h1234AABB, 1'b1, 4'b0011, 1'b1, 0);
        tbl[9]  = mk(4'b0011, 32'h10, 32'hDEAD0009, 32'h1234AABB, 1'b1, 4'b0000, 1'b0, 0);
        tbl[10] = mk(4'b0010, 32'h2000, 32'hDEAD000A, 32'h1234AABB, 1'b1, 4'b1111, 1'b1, 0);
        tbl[11] = mk(4'b1000, 32'h13, 32'hFFFFFF5A, 32'h1234AABB, 1'b0, 4'b1000, 1'b1, 1);
        tbl[12] = mk(4'b0100, 32'h13, 32'hDEAD000C, 32'h0000005A, 1'b0, 4'b1000, 1'b1, 0);
        tbl[13] = mk(4'b0000, 32'h10, 32'hDEAD000D, 32'hFFFFFFBB, 1'b0, 4'b0001, 1'b1, 0);
        tbl[14] = mk(4'b0000, 32'h11, 32'hDEAD000E, 32'hFFFFFFAA, 1'b0, 4'b0010, 1'b1, 0);
        tbl[15] = mk(4'b1010, 32'h14, 32'hCAFEF00D, 32'hFFFFFFAA, 1'b0, 4'b1111, 1'b1, 1);
        tbl[16] = mk(4'b0010, 32'h14, 32'hDEAD0010, 32'hCAFEF00D, 1'b0, 4'b1111, 1'b1, 0);
        tbl[17] = mk(4'b0001, 32'h16, 32'hDEAD0011, 32'hFFFFCAFE, 1'b0, 4'b1100, 1'b1, 0);
        tbl[18] = mk(4'b0101, 32'h14, 32'hDEAD0012, 32'h0000F00D, 1'b0, 4'b0011, 1'b1, 0);
        tbl[19] = mk(4'b0100, 32'h15, 32'hDEAD0013, 32'h000000F0, 1'b0, 4'b0010, 1'b1, 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {28'd0, busy, done, err, dm_we}, 32'd0);
        check("reset_rdata", rdata_out, 32'd0);
        check("reset_addr", 32'(dm_addr), 32'd0);
        check("reset_be", 32'(dm_be), 32'd0);
        check("reset_din", dm_din, 32'd0);
        preload = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 20; i++) run_cmd(i);

        // Restore the reference word
        @(posedge clk); #1 preload = 1'b1;
        @(posedge clk); #1 preload = 1'b0;

        // Extra start pulses (a store) while busy must be ignored
        dn = 0; we0 = we_cnt;
        @(negedge clk);
        start = 1'b1; op = 4'b0010; addr_in = 32'h10; wdata_in = 32'd0;
        @(posedge clk); #1;
        for (int c = 1; c <= 10; c++) begin
            if (done === 1'b1) dn = dn + 1;
            @(negedge clk);
            if (c <= 2) begin
                start = 1'b1; op = 4'b1010; addr_in = 32'h10; wdata_in = 32'h0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("ign_dones", 32'(dn), 32'd1);
        check("ign_we", 32'(we_cnt - we0), 32'd0);
        check("ign_rdata", rdata_out, 32'h8899AABB);
        check("ign_mem", mem[4], 32'h8899AABB);

        // Back-to-back with start held: one command per 4 cycles
        @(negedge clk);
        start = 1'b1; op = 4'b0010; addr_in = 32'h10;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pos.push_back(c);
        end
        @(negedge clk); start = 1'b0;
        check("b2b_count", 32'(pos.size()), 32'd3);
        if (pos.size() >= 2) begin
            check("b2b_first", 32'(pos[0]), 32'd3);
            check("b2b_period", 32'(pos[1] - pos[0]), 32'd4);
        end
        dn = 0;
        while (busy === 1'b1 && dn < 10) begin
            @(posedge clk); #1;
            dn = dn + 1;
        end
        check("b2b_drain", 32'(busy), 32'd0);

        // Reset during ADDR of a byte store: no write, no done
        we0 = we_cnt;
        @(negedge clk);
        start = 1'b1; op = 4'b1000; addr_in = 32'h10; wdata_in = 32'h000000EE;
        @(posedge clk); #1;
        check("rst_busy_addr", 32'(busy), 32'd1);
        @(negedge clk); rst_n = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("rst_ctrl", {29'd0, busy, done, dm_we}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dn = dn + 1;
        end
        check("rst_nodone", 32'(dn), 32'd0);
        check("rst_we", 32'(we_cnt - we0), 32'd0);
        check("rst_mem", mem[4], 32'h8899AABB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

endmodule
